// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
// Purpose: FSM state encoding, default register-number width, register-0 index.
package pipe_ctrl_pkg;

   localparam int REG_W    = 3;
   localparam int REG_ZERO = 0;   // writes to r0 are discarded, so r0 never carries a hazard

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_e;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator
// Purpose: flags an ID-stage instruction that reads the register a load in EX is about to write.
// Ports:
//   id_rs, id_rt  source registers of the instruction in ID
//   id_uses_rt    ID instruction actually reads rt
//   ex_MemRead    instruction in EX is a load
//   ex_rt         load destination register
//   load_use      hazard present this cycle
module load_use_detect #(
   parameter int REG_W = pipe_ctrl_pkg::REG_W
) (
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_MemRead,
   input  logic [REG_W-1:0] ex_rt,
   output logic             load_use
);
   import pipe_ctrl_pkg::*;

   logic rs_hit;
   logic rt_hit;

   assign rs_hit   = (ex_rt == id_rs);
   // rt only matters when the ID instruction uses it as a source (not as a destination)
   assign rt_hit   = id_uses_rt & (ex_rt == id_rt);
   assign load_use = ex_MemRead & (ex_rt != REG_W'(REG_ZERO)) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline register sequencing, hazard stall, branch flush, memory freeze
// Purpose: drives per-stage write/flush enables and pc_src for a 5-stage pipeline, tracks slow
//          data-memory waits with a timeout, and keeps saturating stall/flush statistics.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt        ID-stage source registers
//   ex_MemRead, ex_rt               load in EX and its destination
//   mem_access, mem_ready           MEM-stage memory access and completion
//   mem_branch_taken                branch resolved taken in MEM
//   pc_write, pc_src                PC load enable and branch-target select
//   *_write, *_flush                per-stage register load / bubble enables
//   err, state                      sticky timeout error, current FSM state
//   stall_cnt, flush_cnt            saturating event counters
module pipeline_hazard_ctrl #(
   parameter int REG_W       = pipe_ctrl_pkg::REG_W,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_MemRead,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             mem_access,
   input  logic             mem_ready,
   input  logic             mem_branch_taken,
   output logic             pc_write,
   output logic             pc_src,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             ex_mem_flush,
   output logic             mem_wb_flush,
   output logic             err,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   import pipe_ctrl_pkg::*;

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT == 0) ? '0 : WAIT_W'(MEM_TIMEOUT - 1);

   state_e            state_q;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic              err_q;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic load_use;
   logic freeze;
   logic stall_apply;
   logic flush_apply;

   load_use_detect #(.REG_W(REG_W)) u_lud (
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .ex_MemRead (ex_MemRead),
      .ex_rt      (ex_rt),
      .load_use   (load_use)
   );

   // Mealy control: outputs follow inputs in the same cycle
   always_comb begin
      pc_write     = 1'b1;
      pc_src       = 1'b0;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b1;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b1;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      freeze       = 1'b0;
      stall_apply  = 1'b0;
      flush_apply  = 1'b0;

      if (rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         mem_wb_flush = 1'b1;
      end else begin
         case (state_q)
            RUN:      freeze = mem_access & ~mem_ready;
            MEM_WAIT: freeze = ~mem_ready;
            default:  freeze = 1'b1;
         endcase

         if (freeze) begin
            // Whole pipe holds; only MEM/WB takes a bubble so WB does not repeat an instruction.
            // A pending branch stays in EX/MEM and is acted on once memory completes.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
         end else if (mem_branch_taken) begin
            // The load-use instruction, if any, is on the wrong path and gets flushed here.
            pc_src       = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            flush_apply  = 1'b1;
         end else if (load_use) begin
            // Next cycle the load has moved to MEM, so the hazard clears after one bubble.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
            stall_apply  = 1'b1;
         end
      end
   end

   assign stall_cnt_d = (stall_apply && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
   assign flush_cnt_d = (flush_apply && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         case (state_q)
            RUN: begin
               if (freeze) begin
                  state_q    <= MEM_WAIT;
                  wait_cnt_q <= WAIT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (!mem_ready) begin
                  if (MEM_TIMEOUT != 0 && wait_cnt_q >= WAIT_LAST) begin
                     state_q <= ERROR;
                     err_q   <= 1'b1;
                  end else if (wait_cnt_q != '1) begin
                     wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                  end
               end else begin
                  state_q    <= RUN;
                  wait_cnt_q <= '0;
               end
            end
            default: begin
               state_q <= ERROR;
               err_q   <= 1'b1;
            end
         endcase
      end
   end

   assign err       = err_q;
   assign state     = state_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

   localparam int REG_W = 3;
   localparam int CNT_W = 4;
   localparam int TO    = 6;
   localparam int CMAX  = (1 << CNT_W) - 1;

   // ctrl bit order: pc_write pc_src if_id_write if_id_flush id_ex_write id_ex_flush ex_mem_write ex_mem_flush mem_wb_flush
   localparam logic [8:0] C_DEF = 9'b101010100;
   localparam logic [8:0] C_FRZ = 9'b000000001;
   localparam logic [8:0] C_BR  = 9'b111111110;
   localparam logic [8:0] C_LU  = 9'b000011100;
   localparam logic [8:0] C_RST = 9'b000101011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [REG_W-1:0] id_rs, id_rt, ex_rt;
   logic             id_uses_rt, ex_MemRead, mem_access, mem_ready, mem_branch_taken;
   logic             pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
   logic             ex_mem_write, ex_mem_flush, mem_wb_flush, err;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [8:0]       ctrl;

   assign ctrl = {pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                  ex_mem_write, ex_mem_flush, mem_wb_flush};

   pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .mem_access(mem_access), .mem_ready(mem_ready),
      .mem_branch_taken(mem_branch_taken), .pc_write(pc_write), .pc_src(pc_src),
      .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
      .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush),
      .mem_wb_flush(mem_wb_flush), .err(err), .state(state), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
   );

   typedef struct {
      logic       rst;
      logic [2:0] rs;
      logic [2:0] rt;
      logic       uses_rt;
      logic       memread;
      logic [2:0] ex_rt;
      logic       acc;
      logic       rdy;
      logic       br;
   } in_t;

   typedef struct {
      in_t        in;
      logic [8:0] exp_ctrl;
      string      name;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: mode 0 running, 1 waiting on memory, 2 timed out
   int m_mode, m_wait, m_stall, m_flush, m_err;

   task automatic chk(string nm, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic in_t mk(logic r, int rs, int rt, logic ur, logic mr, int er,
                              logic acc, logic rdy, logic br);
      in_t v;
      v.rst = r; v.rs = 3'(rs); v.rt = 3'(rt); v.uses_rt = ur; v.memread = mr;
      v.ex_rt = 3'(er); v.acc = acc; v.rdy = rdy; v.br = br;
      return v;
   endfunction

   function automatic logic [8:0] model_ctrl(in_t v, int mode, output bit fz, output bit lu);
      lu = v.memread && (v.ex_rt != 0) && ((v.ex_rt == v.rs) || (v.uses_rt && v.ex_rt == v.rt));
      fz = (mode == 2) || (mode == 1 && !v.rdy) || (mode == 0 && v.acc && !v.rdy);
      if (v.rst) begin fz = 1'b0; return C_RST; end
      if (fz)    return C_FRZ;
      if (v.br)  return C_BR;
      if (lu)    return C_LU;
      return C_DEF;
   endfunction

   task automatic cyc(in_t v, bit use_tbl, logic [8:0] texp, string nm);
      logic [8:0] e;
      bit fz, lu;
      rst = v.rst; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; ex_MemRead = v.memread;
      ex_rt = v.ex_rt; mem_access = v.acc; mem_ready = v.rdy; mem_branch_taken = v.br;
      @(negedge clk);
      e = model_ctrl(v, m_mode, fz, lu);
      chk({nm, " ctrl"}, int'(ctrl), int'(e));
      chk({nm, " state"}, int'(state), m_mode);
      chk({nm, " err"}, int'(err), m_err);
      chk({nm, " stall_cnt"}, int'(stall_cnt), m_stall);
      chk({nm, " flush_cnt"}, int'(flush_cnt), m_flush);
      if (use_tbl) chk({nm, " table"}, int'(ctrl), int'(texp));
      @(posedge clk);
      if (v.rst) begin
         m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_err = 0;
      end else begin
         if (!fz && v.br)            m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
         else if (!fz && lu)         m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
         if (m_mode == 2) begin
            m_err = 1;
         end else if (fz && m_mode == 0) begin
            m_mode = 1; m_wait = 1;
         end else if (fz) begin
            if (m_wait >= TO - 1) begin m_mode = 2; m_err = 1; end
            else m_wait++;
         end else begin
            m_mode = 0; m_wait = 0;
         end
      end
      #1;
   endtask

   vec_t tbl[$];

   initial begin
      in_t r;
      m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_err = 0;
      rst = 1'b1; id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 1'b0; ex_MemRead = 1'b0;
      mem_access = 1'b0; mem_ready = 1'b1; mem_branch_taken = 1'b0;

      tbl.push_back('{mk(1,0,0,0,0,0,0,1,0), C_RST, "reset"});
      tbl.push_back('{mk(0,1,2,1,0,0,0,1,0), C_DEF, "idle"});
      tbl.push_back('{mk(0,3,1,0,1,3,0,1,0), C_LU,  "lu_rs"});
      tbl.push_back('{mk(0,0,0,1,1,0,0,1,0), C_DEF, "lu_r0"});
      tbl.push_back('{mk(0,1,5,0,1,5,0,1,0), C_DEF, "rt_unused"});
      tbl.push_back('{mk(0,1,5,1,1,5,0,1,0), C_LU,  "lu_rt"});
      tbl.push_back('{mk(0,3,1,0,1,3,0,1,1), C_BR,  "br_over_lu"});
      tbl.push_back('{mk(0,0,0,0,0,0,1,1,0), C_DEF, "mem_fast"});
      tbl.push_back('{mk(0,3,1,0,1,3,1,0,1), C_FRZ, "freeze_over_br"});
      tbl.push_back('{mk(0,3,1,0,1,3,1,1,1), C_BR,  "wait_done_br"});
      tbl.push_back('{mk(0,4,4,1,0,4,0,1,0), C_DEF, "no_memread"});
      foreach (tbl[i]) cyc(tbl[i].in, 1'b1, tbl[i].exp_ctrl, tbl[i].name);
      chk("table stall_cnt", int'(stall_cnt), 2);
      chk("table flush_cnt", int'(flush_cnt), 2);
      chk("table state", int'(state), 0);

      // branch together with load-use: only the flush is counted
      cyc(mk(1,0,0,0,0,0,0,1,0), 1'b1, C_RST, "rst_a");
      cyc(mk(0,3,0,0,1,3,0,1,1), 1'b1, C_BR, "br_lu");
      chk("br_lu stall_cnt", int'(stall_cnt), 0);
      chk("br_lu flush_cnt", int'(flush_cnt), 1);

      // five-cycle memory wait then completion
      for (int i = 0; i < 5; i++) begin
         cyc(mk(0,0,0,0,0,0,1,0,0), 1'b1, C_FRZ, "wait5");
         chk("wait5 state", int'(state), 1);
      end
      cyc(mk(0,0,0,0,0,0,1,1,0), 1'b1, C_DEF, "wait5_done");
      chk("wait5_done state", int'(state), 0);

      // timeout into ERROR, ready ignored, then reset recovers
      for (int i = 0; i < TO; i++) cyc(mk(0,0,0,0,0,0,1,0,0), 1'b1, C_FRZ, "timeout");
      chk("timeout state", int'(state), 2);
      chk("timeout err", int'(err), 1);
      cyc(mk(0,3,0,0,1,3,0,1,1), 1'b1, C_FRZ, "error_hold");
      chk("error_hold state", int'(state), 2);
      cyc(mk(1,0,0,0,0,0,0,1,0), 1'b1, C_RST, "rst_err");
      chk("rst_err state", int'(state), 0);
      chk("rst_err err", int'(err), 0);
      chk("rst_err flush_cnt", int'(flush_cnt), 0);

      // stall counter saturation
      for (int i = 0; i < CMAX + 4; i++) cyc(mk(0,2,0,0,1,2,0,1,0), 1'b1, C_LU, "sat");
      chk("sat stall_cnt", int'(stall_cnt), CMAX);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         r = mk($urandom_range(0, 59) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
         cyc(r, 1'b0, C_DEF, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
